npu_act_packer: RTL and testbench

//  Receiving end of the activation stream leaving npu_relu (valid-only, no backpressure).

---
 rtl/npu_act_packer.sv | 173 +++++++++++++++++
 tb/tb_npu_act_packer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_act_packer.sv
// rtl/npu_act_packer.sv - requantize, pack and buffer activation samples into ready/valid words

package npu_pkg;
    localparam int M_LEN = 16;
endpackage

module npu_act_packer #(
    parameter int DATA_W = npu_pkg::M_LEN,
    parameter int OUT_W  = 8,
    parameter int PACK   = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16,
    localparam int SH_W  = $clog2(DATA_W)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DATA_W-1:0]      data_i,
    input  logic                   valid_i,
    input  logic                   last_i,
    input  logic [SH_W-1:0]        shift_i,
    input  logic                   clear_i,
    output logic [PACK*OUT_W-1:0]  data_o,
    output logic [PACK-1:0]        keep_o,
    output logic                   last_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   ovf_o,
    output logic [CNT_W-1:0]       sat_cnt_o
);

    localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int ADR_W = PTR_W - 1;
    localparam int ENT_W = 1 + PACK + PACK * OUT_W;

    // requantization datapath
    logic [DATA_W:0]          rnd_full;
    logic [DATA_W:0]          rnd;
    logic signed [DATA_W:0]   sum;
    logic signed [DATA_W:0]   r;
    logic                     neg;
    logic                     over;
    logic [OUT_W-1:0]         q;

    // packing state
    logic [PACK-1:0][OUT_W-1:0] lanes;
    logic [PACK-1:0][OUT_W-1:0] word_data;
    logic [PACK-1:0]            word_keep;
    logic [IDX_W-1:0]           idx;
    logic                       complete;

    // fifo state
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              push_ok;
    logic              drop;
    logic [ENT_W-1:0]  head;

    logic              ovf;
    logic [CNT_W-1:0]  sat_cnt;

    // round-half-up in DATA_W+1 bits, arithmetic shift, then clamp to the unsigned lane range
    always_comb begin
        rnd_full = {{DATA_W{1'b0}}, 1'b1} << shift_i;
        rnd      = rnd_full >> 1;
        sum      = $signed({data_i[DATA_W-1], data_i}) + $signed(rnd);
        r        = sum >>> shift_i;
        neg      = r[DATA_W];
        over     = !neg && (|r[DATA_W-1:OUT_W]);
        if (neg) begin
            q = '0;
        end else if (over) begin
            q = '1;
        end else begin
            q = r[OUT_W-1:0];
        end
    end

    // assemble the word as it would look with the current sample merged in
    always_comb begin
        word_data      = lanes;
        word_data[idx] = q;
        for (int i = 0; i < PACK; i++) begin
            word_keep[i] = (IDX_W'(i) <= idx);
        end
        complete = valid_i && ((idx == IDX_W'(PACK - 1)) || last_i);
    end

    // fifo status and push/pop decisions
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                  (wr_ptr[ADR_W-1:0] == rd_ptr[ADR_W-1:0]);
        pop     = !empty && ready_i;
        push    = complete;
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
    end

    // pack register: lanes restart at zero so unwritten lanes of the next word read as 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lanes <= '0;
            idx   <= '0;
        end else if (valid_i) begin
            if (complete) begin
                lanes <= '0;
                idx   <= '0;
            end else begin
                lanes[idx] <= q;
                idx        <= idx + 1'b1;
            end
        end
    end

    // fifo storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr[ADR_W-1:0]] <= {last_i, word_keep, word_data};
        end
    end

    // fifo pointers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // sticky overflow and saturating clip counter; clear takes priority over new events
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf     <= 1'b0;
            sat_cnt <= '0;
        end else if (clear_i) begin
            ovf     <= 1'b0;
            sat_cnt <= '0;
        end else begin
            if (drop) begin
                ovf <= 1'b1;
            end
            if (valid_i && over && (sat_cnt != '1)) begin
                sat_cnt <= sat_cnt + 1'b1;
            end
        end
    end

    // first-word-fall-through view of the fifo head, forced to zero while empty
    always_comb begin
        head    = empty ? '0 : mem[rd_ptr[ADR_W-1:0]];
        valid_o = !empty;
        last_o  = head[ENT_W-1];
        keep_o  = head[ENT_W-2 -: PACK];
        data_o  = head[PACK*OUT_W-1:0];
    end

    assign ovf_o     = ovf;
    assign sat_cnt_o = sat_cnt;

endmodule

// File: tb/tb_npu_act_packer.sv
// tb/tb_npu_act_packer.sv - scoreboard bench for npu_act_packer

module tb_npu_act_packer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] data_i;
    logic        valid_i;
    logic        last_i;
    logic [3:0]  shift_i;
    logic        clear_i;
    logic [31:0] data_o;
    logic [3:0]  keep_o;
    logic        last_o;
    logic        valid_o;
    logic        ready_i;
    logic        ovf_o;
    logic [15:0] sat_cnt_o;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } word_t;

    word_t sb[$];
    word_t cur;
    word_t front;
    int    idx_m   = 0;
    logic  exp_ovf = 1'b0;
    int    exp_sat = 0;
    int    n_pass  = 0;
    int    n_total = 0;
    int    pops    = 0;

    always #5 clk = ~clk;

    npu_act_packer dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .last_i    (last_i),
        .shift_i   (shift_i),
        .clear_i   (clear_i),
        .data_o    (data_o),
        .keep_o    (keep_o),
        .last_o    (last_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .ovf_o     (ovf_o),
        .sat_cnt_o (sat_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int requant(input int d, input int s);
        int r;
        r = (d + ((s != 0) ? (1 << (s - 1)) : 0)) >>> s;
        return r;
    endfunction

    // drive one sample and update the reference model of packing, fifo and counters
    task automatic sample(input int d, input bit lst = 1'b0, input bit clr = 1'b0);
        int  r;
        int  q;
        bit  done;
        r = requant(d, int'(shift_i));
        q = (r < 0) ? 0 : (r > 255) ? 255 : r;
        data_i  = 16'(d);
        valid_i = 1'b1;
        last_i  = lst;
        clear_i = clr;
        cur.data[idx_m*8 +: 8] = 8'(q);
        done = (idx_m == 3) || lst;
        if (done) begin
            cur.keep = 4'((1 << (idx_m + 1)) - 1);
            cur.last = lst;
            if (sb.size() < 4 || (ready_i && sb.size() > 0)) begin
                sb.push_back(cur);
            end else begin
                exp_ovf = 1'b1;
            end
            cur   = '0;
            idx_m = 0;
        end else begin
            idx_m++;
        end
        if (clr) begin
            exp_ovf = 1'b0;
            exp_sat = 0;
        end else if (r > 255 && exp_sat < 65535) begin
            exp_sat++;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && valid_o; i++) begin
            @(posedge clk);
            #1;
        end
        check(tag, valid_o, 0);
    endtask

    // scoreboard: every word leaving the port must match the oldest expected word
    always @(negedge clk) begin
        if (!rst_i && valid_o && ready_i) begin
            n_total++;
            assert (sb.size() > 0) n_pass++;
            else $error("FAIL unexpected_word: observed %0h expected none", data_o);
            if (sb.size() > 0) begin
                front = sb.pop_front();
                check("fifo_word", {last_o, keep_o, data_o}, front);
                pops++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i   = 1'b1;
        data_i  = '0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        shift_i = '0;
        clear_i = 1'b0;
        ready_i = 1'b0;
        cur     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        check("rst_valid", valid_o, 0);
        check("rst_last", last_o, 0);
        check("rst_keep", keep_o, 0);
        check("rst_data", data_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_sat", sat_cnt_o, 0);

        // rounding with shift 8 and a negative sample clamped to zero
        shift_i = 4'd8;
        sample(256);
        sample(383);
        sample(384);
        check("t1_not_yet", valid_o, 0);
        sample(-5);
        check("t1_valid", valid_o, 1);
        check("t1_data", data_o, 32'h00020101);
        check("t1_keep", keep_o, 4'hF);
        check("t1_last", last_o, 0);
        check("t1_sat", sat_cnt_o, 0);
        ready_i = 1'b1;
        drain("t1_drain");

        // upper clip counting, clear priority, exact 255 not counted
        shift_i = 4'd0;
        sample(300);
        check("t2_sat1", sat_cnt_o, 1);
        check("t2_sat1_model", sat_cnt_o, 64'(exp_sat));
        sample(300, 1'b0, 1'b1);
        check("t2_sat_clear", sat_cnt_o, 0);
        sample(255);
        check("t2_sat_255", sat_cnt_o, 0);
        sample(-1, 1'b1);
        check("t2_sat_model", sat_cnt_o, 64'(exp_sat));
        drain("t2_drain");

        // short tensor closed by last
        ready_i = 1'b0;
        sample(1);
        sample(2);
        sample(3, 1'b1);
        check("t3_valid", valid_o, 1);
        check("t3_data", data_o, 32'h00030201);
        check("t3_keep", keep_o, 4'h7);
        check("t3_last", last_o, 1);
        ready_i = 1'b1;
        drain("t3_drain");

        // overflow: five words into a four-deep fifo with no reads
        ready_i = 1'b0;
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < 4; k++) begin
                sample(w * 4 + k + 1);
            end
        end
        check("t4_ovf", ovf_o, 1);
        check("t4_ovf_model", ovf_o, exp_ovf);
        check("t4_head", data_o, 32'h04030201);
        check("t4_held", valid_o, 1);
        pops    = 0;
        ready_i = 1'b1;
        drain("t4_drain");
        check("t4_pops", pops, 4);
        clear_i = 1'b1;
        exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        check("t4_ovf_clear", ovf_o, 0);

        // full fifo with a simultaneous read absorbs the new word
        ready_i = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) begin
                sample(40 + w * 4 + k);
            end
        end
        sample(100);
        sample(101);
        sample(102);
        ready_i = 1'b1;
        sample(103);
        ready_i = 1'b0;
        check("t5_no_ovf", ovf_o, 0);
        check("t5_ovf_model", ovf_o, exp_ovf);
        pops    = 0;
        ready_i = 1'b1;
        drain("t5_drain");
        check("t5_occupancy", pops, 4);

        // reset mid-stream discards queued words and the partial word
        ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sample(k + 1);
        end
        rst_i = 1'b1;
        sb.delete();
        cur     = '0;
        idx_m   = 0;
        exp_ovf = 1'b0;
        exp_sat = 0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        check("t6_valid", valid_o, 0);
        check("t6_ovf", ovf_o, 0);
        pops    = 0;
        ready_i = 1'b1;
        sample(10);
        sample(20);
        sample(30);
        sample(40);
        check("t6_word", data_o, 32'h281E140A);
        drain("t6_drain");
        check("t6_pops", pops, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
